exponent_update_pipe: RTL and testbench
=======================================

# exponent_update_pipe

Parametrised, two-stage pipelined exponent-update stage for the pipelined FP adder. Takes the pre-normalisation exponent, the adder-output MSBs and the normalisation shift amounts, and produces the signed internal exponent together with a saturated result exponent and overflow, underflow and zero flags. Widths are generic, so one block serves single- and double-precision datapaths. Sits between the normalise/round stage and the pack stage, with valid/ready backpressure through both stages.

## Interface
Parameters:
- EXP_W, 8, exponent field width.
- SUM_W, 27, adder-sum width (mantissa plus guard/round/sticky bits); must be at least 3.
- SHIFT_W, 5, width of the massive left-shift count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both pipeline valids.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  stage 1 can accept a transaction.
- ovf  in  1  adder carry-out.
- ovf_rnd  in  1  rounding carry-out.
- one_shift_left  in  1  a 1-bit left normalise was applied.
- sum  in  SUM_W  adder sum.
- base_exp  in  EXP_W  pre-normalisation (larger-operand) exponent.
- massive_shift_left  in  SHIFT_W  leading-zero shift count.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- exp_int  out  EXP_W+2  signed internal exponent (two's complement).
- exp_out  out  EXP_W  saturated result exponent.
- overflow_flag, underflow_flag, zero_flag  out  1 each.

## Operation
- Path select: the left path is taken when {ovf, sum[SUM_W-1], sum[SUM_W-2]} == 3'b000. Otherwise the right path is taken.
- Left path: exp_int = base_exp + ovf - massive_shift_left. In this path ovf = 0, so the result reduces to base_exp - massive_shift_left.
- Right path: exp_int = base_exp + ovf + ovf_rnd - one_shift_left.
- Width rules:
  - All operands are zero-extended to EXP_W+2 bits before the arithmetic.
  - The result is interpreted as signed.
  - No wrap-around is possible within the specified operand ranges.
- Stage 1 registers:
  - the zero-extended base_exp;
  - the signed adjust term (+ovf+ovf_rnd-one_shift_left, or -massive_shift_left);
  - the zero condition (sum == 0 and ovf == 0).
- Stage 2 registers: exp_int = base + adjust, plus the flags and exp_out.
- Flag and saturation rules, in priority order:
  - zero: zero_flag = 1, exp_int = 0, exp_out = 0, other flags 0.
  - exp_int ≥ 2^EXP_W - 1: overflow_flag = 1, exp_out = all ones.
  - exp_int ≤ 0 (signed): underflow_flag = 1, exp_out = 0.
  - otherwise: exp_out = exp_int[EXP_W-1:0].
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - Stage 1 loads when in_valid && in_ready; stage 2 loads from stage 1 when s1_valid && s2_adv.
  - A stage with nothing to load drops its valid if its output is consumed.
  - Stalled stages hold data and valid unchanged.
- Data registers load only on an accepted transfer and are otherwise held.
- out_valid = s2_valid.
- Outputs exp_int, exp_out and the flags are driven directly from stage-2 registers.

## Timing
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 transaction per cycle.
- in_ready is combinational from out_ready and the valids. There is no combinational path from the data inputs to the outputs.
- Reset (asynchronous, any time, including mid-stream):
  - both valids are 0, so out_valid = 0 and in_ready = 1;
  - all data registers, exp_int, exp_out and all flags are 0;
  - in-flight transactions are discarded.
- flush: at the next edge both valids clear. Any input presented in the same cycle is dropped. Data registers are not cleared.
- Simultaneous events:
  - accept, advance and output-consume in the same cycle are all honoured;
  - a full pipeline with out_ready = 1 accepts a new input every cycle;
  - when out_ready is low with both stages full, in_ready = 0.
- out_valid and the data outputs are stable while out_valid = 1 && out_ready = 0.

## Test plan
EXP_W=8, SUM_W=27, SHIFT_W=5 throughout.
- Right path: base_exp=100, ovf=1, ovf_rnd=0, one_shift_left=0, sum=27'h4000000 → two cycles later exp_int=101, exp_out=101, all flags 0.
- Left path: base_exp=100, ovf=0, sum=27'h0800000, massive_shift_left=5 → exp_int=95, exp_out=95.
- Underflow and overflow:
  - base_exp=3, left path, massive_shift_left=10 → exp_int=10'h3F9 (-7), underflow_flag=1, exp_out=0.
  - base_exp=254, ovf=1, ovf_rnd=1 → exp_int=256, overflow_flag=1, exp_out=255.
- Zero: sum=0, ovf=0, base_exp=77 → zero_flag=1, exp_int=0, exp_out=0, other flags 0.
- Backpressure: stream 6 back-to-back inputs with out_ready held low for cycles 3–5 → in_ready deasserts once both stages are full; all 6 results emerge in order with no loss or duplication; outputs are held stable during the stall.
- Reset/flush:
  - assert rst_n low mid-stream → out_valid and all outputs go 0 immediately, without a clock edge.
  - pulse flush with 2 transactions in flight → out_valid=0 on the next cycle and neither result is ever presented.

Source files
------------

// File: rtl/exponent_update_pipe.sv
// Two-stage exponent-update pipeline for the FP adder: computes the signed internal
// exponent, saturated result exponent and overflow/underflow/zero flags.
module exponent_update_pipe #(
    parameter int EXP_W   = 8,
    parameter int SUM_W   = 27,
    parameter int SHIFT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               ovf,
    input  logic               ovf_rnd,
    input  logic               one_shift_left,
    input  logic [SUM_W-1:0]   sum,
    input  logic [EXP_W-1:0]   base_exp,
    input  logic [SHIFT_W-1:0] massive_shift_left,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+1:0]   exp_int,
    output logic [EXP_W-1:0]   exp_out,
    output logic               overflow_flag,
    output logic               underflow_flag,
    output logic               zero_flag
);

    localparam int XW = EXP_W + 2;
    localparam logic [XW-1:0] MAX_E = {2'b00, {EXP_W{1'b1}}};

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, s1_load, s2_load;

    logic [XW-1:0] s1_base_q, s1_base_d;
    logic [XW-1:0] s1_adj_q, s1_adj_d;
    logic          s1_zero_q, s1_zero_d;

    logic [XW-1:0]    s2_exp_q, s2_exp_d;
    logic [EXP_W-1:0] s2_eout_q, s2_eout_d;
    logic             s2_ovf_q, s2_ovf_d;
    logic             s2_unf_q, s2_unf_d;
    logic             s2_zero_q, s2_zero_d;

    logic          left_path;
    logic [XW-1:0] msl_x, ovf_x, rnd_x, osl_x;
    logic [XW-1:0] exp_sum;

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
        s1_load  = in_valid && s1_adv;
        s2_load  = s1_valid_q && s2_adv;

        s1_valid_d = flush ? 1'b0 : (s1_adv ? in_valid : s1_valid_q);
        s2_valid_d = flush ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
    end

    // Stage 1: split the update into an unsigned base and a signed adjust term.
    always_comb begin
        left_path = !(ovf || sum[SUM_W-1] || sum[SUM_W-2]);
        msl_x     = {{(XW-SHIFT_W){1'b0}}, massive_shift_left};
        ovf_x     = {{(XW-1){1'b0}}, ovf};
        rnd_x     = {{(XW-1){1'b0}}, ovf_rnd};
        osl_x     = {{(XW-1){1'b0}}, one_shift_left};
        s1_base_d = {2'b00, base_exp};
        s1_adj_d  = left_path ? ('0 - msl_x) : (ovf_x + rnd_x - osl_x);
        s1_zero_d = (sum == '0) && !ovf;
    end

    always_comb begin
        exp_sum   = s1_base_q + s1_adj_q;
        s2_exp_d  = exp_sum;
        s2_eout_d = exp_sum[EXP_W-1:0];
        s2_ovf_d  = 1'b0;
        s2_unf_d  = 1'b0;
        s2_zero_d = 1'b0;
        if (s1_zero_q) begin
            s2_exp_d  = '0;
            s2_eout_d = '0;
            s2_zero_d = 1'b1;
        end else if ($signed(exp_sum) >= $signed(MAX_E)) begin
            s2_eout_d = '1;
            s2_ovf_d  = 1'b1;
        end else if (exp_sum[XW-1] || exp_sum == '0) begin
            s2_eout_d = '0;
            s2_unf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_base_q  <= '0;
            s1_adj_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_eout_q  <= '0;
            s2_ovf_q   <= 1'b0;
            s2_unf_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) begin
                s1_base_q <= s1_base_d;
                s1_adj_q  <= s1_adj_d;
                s1_zero_q <= s1_zero_d;
            end
            if (s2_load) begin
                s2_exp_q  <= s2_exp_d;
                s2_eout_q <= s2_eout_d;
                s2_ovf_q  <= s2_ovf_d;
                s2_unf_q  <= s2_unf_d;
                s2_zero_q <= s2_zero_d;
            end
        end
    end

    assign out_valid      = s2_valid_q;
    assign exp_int        = s2_exp_q;
    assign exp_out        = s2_eout_q;
    assign overflow_flag  = s2_ovf_q;
    assign underflow_flag = s2_unf_q;
    assign zero_flag      = s2_zero_q;

endmodule

// File: tb/tb_exponent_update_pipe.sv
// Scoreboard bench for exponent_update_pipe: driver pushes model results, monitor pops
// and compares every presented output.
module tb_exponent_update_pipe;

    localparam int EXP_W   = 8;
    localparam int SUM_W   = 27;
    localparam int SHIFT_W = 5;
    localparam int XW      = EXP_W + 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               ovf = 1'b0;
    logic               ovf_rnd = 1'b0;
    logic               one_shift_left = 1'b0;
    logic [SUM_W-1:0]   sum = '0;
    logic [EXP_W-1:0]   base_exp = '0;
    logic [SHIFT_W-1:0] massive_shift_left = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [XW-1:0]      exp_int;
    logic [EXP_W-1:0]   exp_out;
    logic               overflow_flag, underflow_flag, zero_flag;

    typedef struct packed {
        logic [XW-1:0]    ei;
        logic [EXP_W-1:0] eo;
        logic             of;
        logic             uf;
        logic             z;
    } res_t;

    res_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mode = 0;
    int   bp_cyc = 0;
    int   stall_cnt = 0;

    exponent_update_pipe #(.EXP_W(EXP_W), .SUM_W(SUM_W), .SHIFT_W(SHIFT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ovf(ovf), .ovf_rnd(ovf_rnd), .one_shift_left(one_shift_left), .sum(sum),
        .base_exp(base_exp), .massive_shift_left(massive_shift_left),
        .out_valid(out_valid), .out_ready(out_ready), .exp_int(exp_int), .exp_out(exp_out),
        .overflow_flag(overflow_flag), .underflow_flag(underflow_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the exponent-update rules.
    function automatic res_t model(logic o, logic r, logic sl, logic [SUM_W-1:0] s,
                                   logic [EXP_W-1:0] b, logic [SHIFT_W-1:0] m);
        res_t x;
        int   e;
        int   top;
        x   = '0;
        top = int'(s[SUM_W-1 -: 2]);
        if (o == 1'b0 && top == 0) e = int'(b) - int'(m);
        else                       e = int'(b) + int'(o) + int'(r) - int'(sl);
        if (s == 0 && o == 1'b0) begin
            x.z = 1'b1;
        end else begin
            x.ei = XW'(e);
            if (e >= (1 << EXP_W) - 1) begin
                x.of = 1'b1;
                x.eo = '1;
            end else if (e <= 0) begin
                x.uf = 1'b1;
            end else begin
                x.eo = EXP_W'(e);
            end
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic get_ready(output logic r);
        bp_cyc++;
        case (mode)
            0:       r = 1'b1;
            1:       r = ($urandom_range(0, 3) != 0);
            2:       r = !(bp_cyc >= 3 && bp_cyc <= 5);
            default: r = 1'b0;
        endcase
    endtask

    task automatic send(input logic o, input logic r, input logic sl, input logic [SUM_W-1:0] s,
                        input logic [EXP_W-1:0] b, input logic [SHIFT_W-1:0] m);
        int unsigned tries;
        bit          done;
        tries = 0;
        done  = 0;
        while (!done) begin
            @(posedge clk); #1;
            in_valid = 1'b1; ovf = o; ovf_rnd = r; one_shift_left = sl;
            sum = s; base_exp = b; massive_shift_left = m;
            get_ready(out_ready);
            @(negedge clk); #1;
            if (in_ready) begin
                q.push_back(model(o, r, sl, s, b, m));
                done = 1;
            end else begin
                stall_cnt++;
                tries++;
                if (tries > 50) begin
                    check("accept_timeout", 32'(in_ready), 32'd1);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        get_ready(out_ready);
        @(negedge clk); #1;
    endtask

    task automatic rand_send();
        logic [SUM_W-1:0] s;
        logic [EXP_W-1:0] b;
        logic             o;
        int               cat;
        cat = $urandom_range(0, 9);
        o   = 1'b0;
        s   = SUM_W'($urandom);
        if (cat == 0)      s = '0;
        else if (cat <= 4) s[SUM_W-1 -: 2] = 2'b00;
        else               o = 1'($urandom);
        case ($urandom_range(0, 7))
            0:       b = 8'd0;
            1:       b = 8'd1;
            2:       b = 8'd254;
            3:       b = 8'd255;
            default: b = 8'($urandom);
        endcase
        send(o, 1'($urandom), 1'($urandom), s, b, SHIFT_W'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) idle();
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_exp_int"}, 32'(exp_int), 32'd0);
        check({tag, "_exp_out"}, 32'(exp_out), 32'd0);
        check({tag, "_flags"}, 32'({overflow_flag, underflow_flag, zero_flag}), 32'd0);
    endtask

    // Monitor: every presented output is compared against the oldest expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_output", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    checks++;
                    if ({exp_int, exp_out, overflow_flag, underflow_flag, zero_flag} !== e) begin
                        errors++;
                        $display("FAIL result actual ei=%0h eo=%0h of=%0b uf=%0b z=%0b expected ei=%0h eo=%0h of=%0b uf=%0b z=%0b",
                                 exp_int, exp_out, overflow_flag, underflow_flag, zero_flag,
                                 e.ei, e.eo, e.of, e.uf, e.z);
                    end
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        #2 rst_n = 1'b1;

        mode = 0;
        send(1'b1, 1'b0, 1'b0, 27'h4000000, 8'd100, 5'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("latency_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_edge2", 32'(out_valid), 32'd1);
        check("right_exp_int", 32'(exp_int), 32'd101);
        check("right_exp_out", 32'(exp_out), 32'd101);
        @(negedge clk); #1;

        send(1'b0, 1'b0, 1'b0, 27'h0800000, 8'd100, 5'd5);
        send(1'b0, 1'b0, 1'b0, 27'h0000001, 8'd3, 5'd10);
        send(1'b1, 1'b1, 1'b0, 27'h4000000, 8'd254, 5'd0);
        send(1'b0, 1'b0, 1'b0, 27'h0000000, 8'd77, 5'd9);
        send(1'b0, 1'b1, 1'b1, 27'h2000000, 8'd1, 5'd31);
        drain();

        mode = 2;
        bp_cyc = 0;
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) send(1'b0, 1'b0, 1'b0, 27'h0100000, 8'(50 + i), 5'(i));
        check("bp_in_ready_dropped", 32'(stall_cnt > 0), 32'd1);
        mode = 0;
        drain();

        mode = 3;
        send(1'b1, 1'b0, 1'b0, 27'h4000000, 8'd10, 5'd0);
        send(1'b1, 1'b0, 1'b0, 27'h4000000, 8'd20, 5'd0);
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; base_exp = 8'd30;
        @(negedge clk); #1;
        q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("flush_no_result", 32'(out_valid), 32'd0);
        end

        mode = 0;
        for (int i = 0; i < 3; i++) rand_send();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        q.delete();
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        mode = 1;
        for (int i = 0; i < 300; i++) begin
            rand_send();
            if ($urandom_range(0, 4) == 0) idle();
        end
        mode = 0;
        drain();
        idle();
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
